// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// qpsk_pkg : shared state encoding, default constants and the head-detect compare
// Revision 1.0
// ============================================================================
package qpsk_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int SAMP_DIV_D  = 4;
    localparam int SPS_D       = 32;
    localparam int SYMS_D      = 32;
    localparam int THRESH_D    = 60;
    localparam int GAP_TICKS_D = 8;

    // Widening to int keeps -256 representable as a magnitude above any threshold.
    function automatic logic abs_gt(input logic signed [8:0] sample, input int thr);
        int s;
        s = int'(sample);
        return (s > thr) || (s < -thr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// sample_tick_gen : modulo-SAMP_DIV divider with synchronous clear and tick out
// Revision 1.0
// ============================================================================
module sample_tick_gen #(
    parameter int SAMP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int c_w = (SAMP_DIV > 2) ? $clog2(SAMP_DIV) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(SAMP_DIV - 1);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/qpsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// qpsk_rx_ctrl : QPSK receive frame sequencer (head hunt, sample/symbol timing,
//                accumulator control and bit-error-injection schedule)
// Revision 1.0
// ============================================================================
module qpsk_rx_ctrl
    import qpsk_pkg::*;
#(
    parameter int SAMP_DIV       = SAMP_DIV_D,
    parameter int SPS            = SPS_D,
    parameter int SYMS_PER_FRAME = SYMS_D,
    parameter int THRESH         = THRESH_D,
    parameter int GAP_TICKS      = GAP_TICKS_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [8:0] channel_in,
    input  logic        [3:0] ber_period,
    output logic              samp_en,
    output logic        [4:0] phase_idx,
    output logic              acc_load,
    output logic              sym_strobe,
    output logic        [4:0] sym_idx,
    output logic              err_flip,
    output logic              frame_active,
    output logic              frame_done,
    output logic              frame_abort
);

    generate
        if (SAMP_DIV < 2 || SPS < 2 || SPS > 32 || SYMS_PER_FRAME < 1 ||
            SYMS_PER_FRAME > 32 || GAP_TICKS < 1 || GAP_TICKS > 256) begin : g_param_check
            $error("qpsk_rx_ctrl: parameter out of range");
        end
    endgenerate

    localparam logic [4:0] c_ph_last  = 5'(SPS - 1);
    localparam logic [4:0] c_sym_last = 5'(SYMS_PER_FRAME - 1);
    localparam logic [7:0] c_gap_last = 8'(GAP_TICKS - 1);

    state_t     r_state;
    logic       r_start;
    logic [4:0] r_phase_cnt;
    logic [4:0] r_sym_cnt;
    logic [3:0] r_err_cnt;
    logic [7:0] r_gap_cnt;

    logic w_tick;
    logic w_sym_end;
    logic w_frame_end;
    logic w_div_clr;
    logic w_flip;

    // r_phase_cnt counts samples taken since the load; the symbol closes on the
    // tick after the (SPS-1)th sample, giving SPS ticks per symbol.
    assign w_sym_end   = w_tick && (r_phase_cnt == c_ph_last);
    assign w_frame_end = (r_state == RUN) && enable && !r_start && w_sym_end &&
                         (r_sym_cnt == c_sym_last);
    assign w_div_clr   = r_start || w_frame_end;
    assign w_flip      = (ber_period != 4'd0) && (r_err_cnt == ber_period);

    sample_tick_gen #(
        .SAMP_DIV (SAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_div_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= HUNT;
            r_start      <= 1'b0;
            r_phase_cnt  <= 5'd0;
            r_sym_cnt    <= 5'd0;
            r_err_cnt    <= 4'd1;
            r_gap_cnt    <= 8'd0;
            samp_en      <= 1'b0;
            phase_idx    <= 5'd0;
            acc_load     <= 1'b0;
            sym_strobe   <= 1'b0;
            sym_idx      <= 5'd0;
            err_flip     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            samp_en     <= 1'b0;
            acc_load    <= 1'b0;
            sym_strobe  <= 1'b0;
            err_flip    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            case (r_state)
                HUNT: begin
                    frame_active <= 1'b0;
                    if (enable && abs_gt(channel_in, THRESH)) begin
                        r_state <= RUN;
                        r_start <= 1'b1;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        frame_abort  <= 1'b1;
                        frame_active <= 1'b0;
                        r_start      <= 1'b0;
                        r_state      <= HUNT;
                    end else if (r_start) begin
                        r_start      <= 1'b0;
                        acc_load     <= 1'b1;
                        frame_active <= 1'b1;
                        phase_idx    <= 5'd1;
                        sym_idx      <= 5'd0;
                        r_phase_cnt  <= 5'd0;
                        r_sym_cnt    <= 5'd0;
                    end else if (w_sym_end) begin
                        sym_strobe <= 1'b1;
                        sym_idx    <= r_sym_cnt;
                        err_flip   <= w_flip;
                        r_err_cnt  <= w_flip ? 4'd1 : r_err_cnt + 4'd1;
                        if (r_sym_cnt == c_sym_last) begin
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            r_gap_cnt    <= 8'd0;
                            r_state      <= GAP;
                        end else begin
                            acc_load    <= 1'b1;
                            phase_idx   <= 5'd1;
                            r_phase_cnt <= 5'd0;
                            r_sym_cnt   <= r_sym_cnt + 5'd1;
                        end
                    end else if (w_tick) begin
                        samp_en     <= 1'b1;
                        phase_idx   <= r_phase_cnt + 5'd1;
                        r_phase_cnt <= r_phase_cnt + 5'd1;
                    end
                end

                GAP: begin
                    if (!enable) begin
                        r_state <= HUNT;
                    end else if (w_tick) begin
                        if (r_gap_cnt == c_gap_last) begin
                            r_state <= HUNT;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                    end
                end

                default: r_state <= HUNT;
            endcase
        end
    end

endmodule
`default_nettype wire
